// File: rtl/wb_regfile_sb.sv
// rtl/wb_regfile_sb.sv - writeback-side register file with bypass reads and pending-write scoreboard
module wb_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_rf_we,
  input  logic [ADDR_W-1:0] wb_wR,
  input  logic [DATA_W-1:0] wb_wD,
  input  logic [ADDR_W-1:0] rR1,
  input  logic [ADDR_W-1:0] rR2,
  output logic [DATA_W-1:0] rD1,
  output logic [DATA_W-1:0] rD2,
  input  logic              id_issue,
  input  logic [ADDR_W-1:0] id_wR,
  input  logic              flush,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              sb_overflow,
  output logic [31:0]       retire_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              sb_overflow_q, sb_overflow_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic              commit;

  // Writes to x0 are architecturally discarded, so they never count as a commit.
  assign commit = wb_rf_we && (wb_wR != '0);

  // Read port 1: x0 reads zero, a same-cycle commit to the same index is forwarded.
  always_comb begin
    rD1 = regs_q[rR1];
    if (rR1 == '0) begin
      rD1 = '0;
    end else if (commit && (wb_wR == rR1)) begin
      rD1 = wb_wD;
    end
  end

  // Read port 2: same forwarding rules as port 1.
  always_comb begin
    rD2 = regs_q[rR2];
    if (rR2 == '0) begin
      rD2 = '0;
    end else if (commit && (wb_wR == rR2)) begin
      rD2 = wb_wD;
    end
  end

  // A register whose last outstanding write is being forwarded right now is not busy.
  assign rs1_busy = (rR1 != '0) && (cnt_q[rR1] != '0) &&
                    !(commit && (wb_wR == rR1) && (cnt_q[rR1] == CNT_ONE));
  assign rs2_busy = (rR2 != '0) && (cnt_q[rR2] != '0) &&
                    !(commit && (wb_wR == rR2) && (cnt_q[rR2] == CNT_ONE));

  assign sb_overflow = sb_overflow_q;
  assign retire_cnt  = retire_cnt_q;

  // Register file next state and retired-write counter.
  always_comb begin
    regs_d = regs_q;
    retire_cnt_d = retire_cnt_q;
    if (commit) begin
      regs_d[wb_wR] = wb_wD;
      retire_cnt_d  = retire_cnt_q + 32'd1;
    end
  end

  // Pending-write counters: issue increments, commit decrements, flush clears all.
  always_comb begin
    cnt_d         = cnt_q;
    sb_overflow_d = sb_overflow_q;
    for (int i = 1; i < NREG; i++) begin
      logic inc_i;
      logic dec_i;
      inc_i = id_issue && (id_wR == ADDR_W'(i)) && !flush;
      dec_i = commit && (wb_wR == ADDR_W'(i)) && (cnt_q[i] != '0);
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc_i && !dec_i) begin
        if (cnt_q[i] == CNT_MAX) begin
          sb_overflow_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end else if (!inc_i && dec_i) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    cnt_d[0] = '0;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      sb_overflow_q <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      sb_overflow_q <= sb_overflow_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// tb/tb_wb_regfile_sb.sv - scoreboard bench for wb_regfile_sb
module tb_wb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_rf_we;
  logic [4:0]  wb_wR;
  logic [31:0] wb_wD;
  logic [4:0]  rR1, rR2;
  logic [31:0] rD1, rD2;
  logic        id_issue;
  logic [4:0]  id_wR;
  logic        flush;
  logic        rs1_busy, rs2_busy, sb_overflow;
  logic [31:0] retire_cnt;

  localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_OVF = 4, S_RET = 5;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  wb_regfile_sb dut (
    .clk(clk), .rst(rst),
    .wb_rf_we(wb_rf_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
    .rR1(rR1), .rR2(rR2), .rD1(rD1), .rD2(rD2),
    .id_issue(id_issue), .id_wR(id_wR), .flush(flush),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .sb_overflow(sb_overflow), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Advance to just after a rising edge and return all inputs (except rst) to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    wb_rf_we = 1'b0; wb_wR = '0; wb_wD = '0;
    rR1 = '0; rR2 = '0;
    id_issue = 1'b0; id_wR = '0; flush = 1'b0;
  endtask

  task automatic expect_val(input int sel, input logic [31:0] val, input string name);
    exp_t e;
    e.sel = sel; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every falling edge, compare the DUT outputs against what the stimulus expects.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = exp_q.pop_front();
        case (e.sel)
          S_RD1:   act = rD1;
          S_RD2:   act = rD2;
          S_B1:    act = {31'd0, rs1_busy};
          S_B2:    act = {31'd0, rs2_busy};
          S_OVF:   act = {31'd0, sb_overflow};
          default: act = retire_cnt;
        endcase
        n_run++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    wb_rf_we = 1'b0; wb_wR = '0; wb_wD = '0;
    rR1 = '0; rR2 = '0;
    id_issue = 1'b0; id_wR = '0; flush = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    expect_val(S_RET, 32'd0, "reset_retire");
    expect_val(S_OVF, 32'd0, "reset_ovf");
    for (int i = 1; i < 32; i++) begin
      cyc();
      rR1 = 5'(i); rR2 = 5'(32 - i);
      expect_val(S_RD1, 32'd0, "reset_rd1");
      expect_val(S_RD2, 32'd0, "reset_rd2");
      expect_val(S_B1, 32'd0, "reset_busy1");
      expect_val(S_B2, 32'd0, "reset_busy2");
    end

    // Reset asserted while a write is presented
    cyc();
    wb_rf_we = 1'b1; wb_wR = 5'd6; wb_wD = 32'h0000_0055;
    #2 rst = 1'b1;
    cyc();
    rst = 1'b0;
    rR1 = 5'd6;
    expect_val(S_RD1, 32'd0, "midwrite_reset_r6");
    expect_val(S_RET, 32'd0, "midwrite_reset_retire");

    // Commit with same-cycle bypass
    cyc();
    wb_rf_we = 1'b1; wb_wR = 5'd5; wb_wD = 32'hDEAD_BEEF; rR1 = 5'd5;
    expect_val(S_RD1, 32'hDEAD_BEEF, "bypass_rd1");
    expect_val(S_RET, 32'd0, "bypass_retire_before");
    cyc();
    rR1 = 5'd5;
    expect_val(S_RD1, 32'hDEAD_BEEF, "commit_rd1");
    expect_val(S_RET, 32'd1, "commit_retire");
    cyc();
    wb_rf_we = 1'b1; wb_wR = 5'd5; wb_wD = 32'h1111_1111; rR1 = 5'd5; rR2 = 5'd5;
    expect_val(S_RD1, 32'h1111_1111, "bypass2_rd1");
    expect_val(S_RD2, 32'h1111_1111, "bypass2_rd2");
    cyc();
    rR1 = 5'd5;
    expect_val(S_RD1, 32'h1111_1111, "commit2_rd1");
    expect_val(S_RET, 32'd2, "commit2_retire");

    // x0 protection
    cyc();
    wb_rf_we = 1'b1; wb_wR = 5'd0; wb_wD = 32'h1234_5678; rR2 = 5'd0;
    expect_val(S_RD2, 32'd0, "x0_bypass_rd2");
    cyc();
    rR2 = 5'd0; id_issue = 1'b1; id_wR = 5'd0;
    expect_val(S_RD2, 32'd0, "x0_rd2");
    expect_val(S_RET, 32'd2, "x0_retire");
    expect_val(S_B2, 32'd0, "x0_issue_busy_now");
    cyc();
    expect_val(S_B1, 32'd0, "x0_issue_busy1");
    expect_val(S_B2, 32'd0, "x0_issue_busy2");

    // Scoreboard on r7
    cyc();
    id_issue = 1'b1; id_wR = 5'd7; rR1 = 5'd7;
    expect_val(S_B1, 32'd0, "r7_issue1_busy");
    cyc();
    id_issue = 1'b1; id_wR = 5'd7; rR1 = 5'd7;
    expect_val(S_B1, 32'd1, "r7_issue2_busy");
    cyc();
    rR1 = 5'd7;
    expect_val(S_B1, 32'd1, "r7_cnt2_busy");
    cyc();
    wb_rf_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'h70; rR1 = 5'd7;
    expect_val(S_B1, 32'd1, "r7_commit1_busy");
    cyc();
    wb_rf_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'h71; rR1 = 5'd7;
    expect_val(S_B1, 32'd0, "r7_lastcommit_busy");
    expect_val(S_RD1, 32'h71, "r7_lastcommit_rd1");
    cyc();
    rR1 = 5'd7;
    expect_val(S_B1, 32'd0, "r7_cleared_busy");
    expect_val(S_RD1, 32'h71, "r7_cleared_rd1");
    expect_val(S_RET, 32'd4, "r7_retire4");
    cyc();
    id_issue = 1'b1; id_wR = 5'd7;
    cyc();
    id_issue = 1'b1; id_wR = 5'd7; wb_rf_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'h72; rR1 = 5'd7;
    expect_val(S_B1, 32'd0, "r7_inc_dec_busy");
    cyc();
    rR1 = 5'd7;
    expect_val(S_B1, 32'd1, "r7_inc_dec_cnt_kept");
    expect_val(S_RD1, 32'h72, "r7_inc_dec_rd1");
    cyc();
    wb_rf_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'h73; rR1 = 5'd7;
    expect_val(S_B1, 32'd0, "r7_drain_busy");
    cyc();
    wb_rf_we = 1'b1; wb_wR = 5'd7; wb_wD = 32'h74; rR1 = 5'd7;
    expect_val(S_B1, 32'd0, "r7_underflow_busy");
    cyc();
    rR1 = 5'd7;
    expect_val(S_B1, 32'd0, "r7_underflow_after_busy");
    expect_val(S_RD1, 32'h74, "r7_underflow_rd1");
    expect_val(S_RET, 32'd7, "r7_retire7");

    // Saturation on r3
    for (int k = 0; k < 4; k++) begin
      cyc();
      id_issue = 1'b1; id_wR = 5'd3; rR2 = 5'd3;
      expect_val(S_OVF, 32'd0, "sat_ovf_before");
      expect_val(S_B2, (k == 0) ? 32'd0 : 32'd1, "sat_busy");
    end
    cyc();
    rR2 = 5'd3;
    expect_val(S_OVF, 32'd1, "sat_ovf_set");
    expect_val(S_B2, 32'd1, "sat_busy_cnt3");

    // Flush with simultaneous issue and commit
    cyc();
    flush = 1'b1; id_issue = 1'b1; id_wR = 5'd4;
    wb_rf_we = 1'b1; wb_wR = 5'd3; wb_wD = 32'hA5; rR1 = 5'd4; rR2 = 5'd3;
    expect_val(S_RD2, 32'hA5, "flush_bypass_rd2");
    expect_val(S_B2, 32'd1, "flush_cycle_busy_r3");
    expect_val(S_B1, 32'd0, "flush_cycle_busy_r4");
    cyc();
    rR1 = 5'd4; rR2 = 5'd3;
    expect_val(S_B1, 32'd0, "flush_busy_r4");
    expect_val(S_B2, 32'd0, "flush_busy_r3");
    expect_val(S_RD2, 32'hA5, "flush_rd2_r3");
    expect_val(S_OVF, 32'd1, "flush_ovf_sticky");
    expect_val(S_RET, 32'd8, "flush_retire8");

    // retire_cnt wrap
    force dut.retire_cnt_d = 32'hFFFF_FFFF;
    cyc();
    release dut.retire_cnt_d;
    wb_rf_we = 1'b1; wb_wR = 5'd9; wb_wD = 32'h99;
    expect_val(S_RET, 32'hFFFF_FFFF, "wrap_preload");
    cyc();
    rR1 = 5'd9;
    expect_val(S_RET, 32'd0, "wrap_retire0");
    expect_val(S_RD1, 32'h99, "wrap_rd1_r9");

    // Asynchronous reset takes effect before the next clock edge
    cyc();
    rR1 = 5'd9; rR2 = 5'd5;
    rst = 1'b1;
    expect_val(S_RD1, 32'd0, "async_rst_r9");
    expect_val(S_RD2, 32'd0, "async_rst_r5");
    expect_val(S_OVF, 32'd0, "async_rst_ovf");
    expect_val(S_RET, 32'd0, "async_rst_retire");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
